execute_stage: RTL
==================

Name: execute_stage

Overview:
- Execute (EX) stage, directly downstream of the decode-to-execute pipeline register. Consumes operand1, operand2, alu_op and rd.
- Single-cycle ALU ops produce a result one edge after they are presented.
- Multiply/divide/remainder use an iterative 32-step engine. During that engine run the stage raises busy so upstream stalls.
- Outputs are registered and feed the execute-to-writeback register.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- MD_STEPS, 32, iterations of the mul/div engine. Must equal XLEN.

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- flush  input  1  synchronous abort; kills the in-flight op
- halted  input  1  freeze all state and outputs
- operand1_in  input  32  source A
- operand2_in  input  32  source B
- alu_op_in  input  5  operation code; 0 = NOP/bubble
- rd_in  input  5  destination register
- busy  output  1  combinational; upstream must stall while high
- result_out  output  32  registered result
- rd_out  output  5  registered destination
- wb_en_out  output  1  registered; write result_out to rd_out
- illegal_op_out  output  1  registered one-cycle pulse on an unsupported opcode

Behaviour:
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT (signed), 10 SLTU, 11 MUL (low 32 bits), 12 DIVU, 13 REMU, 14-31 illegal.
- Shift amount is operand2_in[4:0]. All add/sub wrap modulo 2^32. SLT/SLTU return 0 or 1.
- Reset: result_out=0, rd_out=0, wb_en_out=0, illegal_op_out=0, state IDLE, step counter 0, internal operand/accumulator registers 0.
- States:
  - IDLE: accepts an op every cycle.
  - MD_BUSY: iterating the engine.
  - MD_DONE: writes the engine result.
- IDLE, single-cycle op (1-10): at the next edge result_out=f(ops), rd_out=rd_in, wb_en_out=(rd_in!=0).
- IDLE, NOP: at the next edge wb_en_out=0, rd_out=0, result_out=0.
- IDLE, illegal op: at the next edge wb_en_out=0 and illegal_op_out=1 for one cycle.
- IDLE, op 11-13:
  - busy is high combinationally in the accept cycle.
  - Operands, op and rd are latched at the edge; state goes to MD_BUSY with counter=0. wb_en_out=0 at that edge.
- MD_BUSY:
  - MUL is shift-add. DIVU/REMU use restoring division, one step per cycle.
  - Counter increments each cycle. After step MD_STEPS-1 the state goes to MD_DONE.
  - busy=1 throughout. Inputs are ignored, including nonzero ops.
- MD_DONE:
  - busy=0, so upstream may present the next op in this cycle.
  - At the edge: result_out=engine result, rd_out=latched rd, wb_en_out=(latched rd!=0), state goes to IDLE.
  - The op present at the input during MD_DONE is NOT executed. Upstream guarantees a bubble here because its stall inserts zeros.
- Latency: single-cycle ops, 1 edge. MUL/DIVU/REMU, result visible MD_STEPS+2 = 34 edges after the accept edge's cycle begins. busy is high for 33 cycles (accept cycle plus 32 MD_BUSY cycles).
- Divide by zero: DIVU returns 0xFFFFFFFF, REMU returns the dividend. No exception, same latency.
- wb_en_out and illegal_op_out are single-cycle pulses per op. Both are 0 on every edge where no op completes.
- Priority: reset > flush > halted > normal.
- flush: state goes to IDLE, counter=0, wb_en_out=0, illegal_op_out=0, rd_out=0, result_out=0. The in-flight mul/div is discarded. busy is 0 from the next cycle.
- halted:
  - All registers (state, counter, engine, outputs) hold their value.
  - busy keeps its state-derived value.
  - Inputs are ignored. No op is accepted while halted.
- Reset mid-operation aborts the engine immediately (asynchronous); all outputs return to their reset values.

Optional Feature:
- EXECUTE_MULDIV_EN defined: opcodes 11-13 behave as above.
- Not defined:
  - The engine and states MD_BUSY/MD_DONE are not built, and busy is tied 0.
  - Opcodes 11-13 are treated as illegal: wb_en_out=0 and illegal_op_out pulses after 1 edge.

Test Plan:
- ADD op1=5, op2=7, rd=3 -> next edge result_out=12, rd_out=3, wb_en_out=1; following edge wb_en_out=0.
- SRA op1=0x80000000, op2=0x24 (shamt 4) -> result_out=0xF8000000. SLT op1=0xFFFFFFFF, op2=1 -> result_out=1. SLTU with the same operands -> result_out=0.
- MUL op1=1234, op2=5678, rd=9 (macro on) -> busy high 33 cycles; result_out=0x006AE9BC, rd_out=9, wb_en_out=1 exactly once. Nonzero ops applied while busy are ignored.
- DIVU 100/7 -> result_out=14. REMU 100/7 -> result_out=2. DIVU 100/0 -> 0xFFFFFFFF. REMU 100/0 -> 100.
- DIVU in flight, flush at step 10 -> no wb_en_out pulse, busy=0 next cycle. Then ADD 1+1, rd=4 -> result_out=2 after 1 edge.
- Single-cycle ops while halted -> outputs frozen. halted during MUL at step 5 for 4 cycles -> result still correct, completion delayed 4 cycles. rd=0 ADD -> wb_en_out=0. Opcode 20 -> illegal_op_out pulse. Macro off, MUL -> illegal_op_out pulse, busy never 1.

Source files
------------

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU plus an optional iterative 32-step MUL/DIVU/REMU engine.
// Define EXECUTE_MULDIV_EN to build the engine; without it opcodes 11-13 are reported illegal.

module execute_stage #(
  parameter int XLEN     = 32,
  parameter int MD_STEPS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            halted,
  input  logic [XLEN-1:0] operand1_in,
  input  logic [XLEN-1:0] operand2_in,
  input  logic [4:0]      alu_op_in,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic [XLEN-1:0] result_out,
  output logic [4:0]      rd_out,
  output logic            wb_en_out,
  output logic            illegal_op_out
);

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_AND  = 5'd3;
  localparam logic [4:0] OP_OR   = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_SLL  = 5'd6;
  localparam logic [4:0] OP_SRL  = 5'd7;
  localparam logic [4:0] OP_SRA  = 5'd8;
  localparam logic [4:0] OP_SLT  = 5'd9;
  localparam logic [4:0] OP_SLTU = 5'd10;
  localparam logic [4:0] OP_MUL  = 5'd11;
  localparam logic [4:0] OP_DIVU = 5'd12;
  localparam logic [4:0] OP_REMU = 5'd13;

  // The engine runs exactly one iteration per result bit.
  if (MD_STEPS != XLEN) begin : g_steps_check
    $error("execute_stage: MD_STEPS must equal XLEN");
  end

  logic [XLEN-1:0] w_alu_result;
  logic            w_single_op;
  logic            w_md_op;
  logic            w_illegal_op;
  logic            w_idle;
  logic [4:0]      w_shamt;

  assign w_shamt = operand2_in[4:0];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_alu_result = '0;
    w_single_op  = 1'b1;
    case (alu_op_in)
      OP_ADD:  w_alu_result = operand1_in + operand2_in;
      OP_SUB:  w_alu_result = operand1_in - operand2_in;
      OP_AND:  w_alu_result = operand1_in & operand2_in;
      OP_OR:   w_alu_result = operand1_in | operand2_in;
      OP_XOR:  w_alu_result = operand1_in ^ operand2_in;
      OP_SLL:  w_alu_result = operand1_in << w_shamt;
      OP_SRL:  w_alu_result = operand1_in >> w_shamt;
      OP_SRA:  w_alu_result = $unsigned($signed(operand1_in) >>> w_shamt);
      OP_SLT:  w_alu_result = {{(XLEN-1){1'b0}}, $signed(operand1_in) < $signed(operand2_in)};
      OP_SLTU: w_alu_result = {{(XLEN-1){1'b0}}, operand1_in < operand2_in};
      default: w_single_op  = 1'b0;
    endcase
  end

`ifdef EXECUTE_MULDIV_EN
  localparam int                CNT_W     = $clog2(MD_STEPS);
  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(MD_STEPS - 1);
  localparam logic [1:0]        ST_IDLE    = 2'd0;
  localparam logic [1:0]        ST_MD_BUSY = 2'd1;
  localparam logic [1:0]        ST_MD_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_count;
  logic [4:0]       r_md_op;
  logic [4:0]       r_md_rd;
  // r_a: multiplicand / dividend-then-quotient; r_b: multiplier / divisor; r_acc: product / remainder
  logic [XLEN-1:0]  r_a;
  logic [XLEN-1:0]  r_b;
  logic [XLEN-1:0]  r_acc;
  logic [XLEN:0]    w_rem_shift;
  logic             w_rem_ge;
  logic [XLEN-1:0]  w_md_result;

  assign w_md_op     = (alu_op_in == OP_MUL) || (alu_op_in == OP_DIVU) || (alu_op_in == OP_REMU);
  assign w_idle      = (r_state == ST_IDLE);
  assign busy        = (r_state == ST_MD_BUSY) || (w_idle && w_md_op);
  // A zero divisor always compares as "fits", giving an all-ones quotient and the dividend as remainder.
  assign w_rem_shift = {r_acc, r_a[XLEN-1]};
  assign w_rem_ge    = (w_rem_shift >= {1'b0, r_b});
  assign w_md_result = (r_md_op == OP_DIVU) ? r_a : r_acc;
`else
  assign w_md_op = 1'b0;
  assign w_idle  = 1'b1;
  assign busy    = 1'b0;
`endif

  assign w_illegal_op = (alu_op_in != OP_NOP) && !w_single_op && !w_md_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_out     <= '0;
      rd_out         <= '0;
      wb_en_out      <= 1'b0;
      illegal_op_out <= 1'b0;
`ifdef EXECUTE_MULDIV_EN
      r_state        <= ST_IDLE;
      r_count        <= '0;
      r_md_op        <= '0;
      r_md_rd        <= '0;
      r_a            <= '0;
      r_b            <= '0;
      r_acc          <= '0;
`endif
    end else if (flush) begin
      result_out     <= '0;
      rd_out         <= '0;
      wb_en_out      <= 1'b0;
      illegal_op_out <= 1'b0;
`ifdef EXECUTE_MULDIV_EN
      r_state        <= ST_IDLE;
      r_count        <= '0;
`endif
    end else if (!halted) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      wb_en_out      <= 1'b0;
      illegal_op_out <= 1'b0;
      if (w_idle) begin
        result_out <= '0;
        rd_out     <= '0;
        if (w_single_op) begin
          result_out <= w_alu_result;
          rd_out     <= rd_in;
          wb_en_out  <= (rd_in != 5'd0);
        end else if (w_illegal_op) begin
          illegal_op_out <= 1'b1;
        end
`ifdef EXECUTE_MULDIV_EN
        else if (w_md_op) begin
          r_a     <= operand1_in;
          r_b     <= operand2_in;
          r_acc   <= '0;
          r_md_op <= alu_op_in;
          r_md_rd <= rd_in;
          r_count <= '0;
          r_state <= ST_MD_BUSY;
        end
`endif
      end
`ifdef EXECUTE_MULDIV_EN
      else if (r_state == ST_MD_BUSY) begin
        if (r_md_op == OP_MUL) begin
          if (r_b[0]) r_acc <= r_acc + r_a;
          r_a <= r_a << 1;
          r_b <= r_b >> 1;
        end else begin
          r_acc <= w_rem_ge ? (w_rem_shift[XLEN-1:0] - r_b) : w_rem_shift[XLEN-1:0];
          r_a   <= {r_a[XLEN-2:0], w_rem_ge};
        end
        r_count <= r_count + 1'b1;
        if (r_count == LAST_STEP) begin
          r_count <= '0;
          r_state <= ST_MD_DONE;
        end
      end else begin
        // The op presented during this cycle is a guaranteed bubble and is not executed.
        result_out <= w_md_result;
        rd_out     <= r_md_rd;
        wb_en_out  <= (r_md_rd != 5'd0);
        r_state    <= ST_IDLE;
      end
`endif
    end
  end

endmodule
